// File: rtl/usb_send_pkt_arbiter_n.sv
// Arbiter for the host controller's single sendPacket transmitter. It serves a
// fixed-priority SOF channel plus NUM_CH round-robin channels, with registered grants and a grant watchdog.
module usb_send_pkt_arbiter_n #(
  parameter int               NUM_CH   = 2,
  parameter int               PID_W    = 4,
  parameter logic [PID_W-1:0] PRIO_PID = 4'h5,
  parameter int               TIMEOUT  = 0,
  parameter int               TO_W     = 16,
  localparam int              ID_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    prio_req,
  input  logic                    prio_wen,
  output logic                    prio_gnt,
  input  logic [NUM_CH-1:0]       ch_req,
  input  logic [NUM_CH*PID_W-1:0] ch_pid,
  input  logic [NUM_CH-1:0]       ch_wen,
  output logic [NUM_CH-1:0]       ch_gnt,
  output logic [PID_W-1:0]        send_pid,
  output logic                    send_wen,
  output logic [ID_W-1:0]         gnt_id,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam logic [TO_W-1:0] WD_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit              WD_ON   = (TIMEOUT > 0);

  typedef enum logic [1:0] {START, IDLE, GNT_PRIO, GNT_CH} stateT;

  stateT             state;
  logic              selPrio;
  logic              prioLock;
  logic [ID_W-1:0]   rrPtr;
  logic [NUM_CH-1:0] lockout;
  logic [TO_W-1:0]   wdCount;

  logic [NUM_CH-1:0] eligible;
  logic              hiValid, loValid, pickValid;
  logic [ID_W-1:0]   hiId, loId, pickId;
  logic [PID_W-1:0]  pidSel;
  logic              wenSel, reqSel;
  logic              wdExpired, revokePrio, revokeCh;

  assign eligible = ch_req & ~lockout;

  // Round robin: prefer the lowest eligible index at or above rrPtr, else wrap to the lowest overall.
  always_comb begin
    hiValid = 1'b0;
    hiId    = '0;
    loValid = 1'b0;
    loId    = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (eligible[k]) begin
        if (ID_W'(k) >= rrPtr) begin
          hiValid = 1'b1;
          hiId    = ID_W'(k);
        end
        loValid = 1'b1;
        loId    = ID_W'(k);
      end
    end
    pickValid = hiValid | loValid;
    pickId    = hiValid ? hiId : loId;
  end

  always_comb begin
    pidSel = ch_pid[PID_W-1:0];
    wenSel = ch_wen[0];
    reqSel = ch_req[0];
    for (int k = 0; k < NUM_CH; k++) begin
      if (gnt_id == ID_W'(k)) begin
        pidSel = ch_pid[k*PID_W +: PID_W];
        wenSel = ch_wen[k];
        reqSel = ch_req[k];
      end
    end
  end

  assign wdExpired   = WD_ON && (wdCount == WD_LAST);
  assign revokePrio  = (state == GNT_PRIO) && prio_req && wdExpired;
  assign revokeCh    = (state == GNT_CH) && reqSel && wdExpired;

  assign send_pid    = selPrio ? PRIO_PID : pidSel;
  assign send_wen    = (prio_gnt & prio_wen) | ((|ch_gnt) & wenSel);
  assign busy        = prio_gnt | (|ch_gnt);

  // A revoked requester stays locked out until it drops its request at least once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= START;
      prio_gnt    <= 1'b0;
      ch_gnt      <= '0;
      gnt_id      <= '0;
      selPrio     <= 1'b0;
      rrPtr       <= '0;
      lockout     <= '0;
      prioLock    <= 1'b0;
      wdCount     <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= revokePrio | revokeCh;
      lockout     <= (lockout & ch_req) | (revokeCh ? ch_gnt : '0);
      prioLock    <= (prioLock & prio_req) | revokePrio;
      wdCount     <= wdCount + TO_W'(1);
      case (state)
        START: state <= IDLE;
        IDLE: begin
          wdCount <= '0;
          if (prio_req && !prioLock) begin
            state    <= GNT_PRIO;
            prio_gnt <= 1'b1;
            selPrio  <= 1'b1;
          end else if (pickValid) begin
            state   <= GNT_CH;
            ch_gnt  <= NUM_CH'(1) << pickId;
            gnt_id  <= pickId;
            selPrio <= 1'b0;
            rrPtr   <= (pickId == ID_W'(NUM_CH - 1)) ? '0 : pickId + ID_W'(1);
          end
        end
        GNT_PRIO: begin
          if (!prio_req || revokePrio) begin
            state    <= IDLE;
            prio_gnt <= 1'b0;
          end
        end
        GNT_CH: begin
          if (!reqSel || revokeCh) begin
            state  <= IDLE;
            ch_gnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
